// File: rtl/xmem_dma_pkg.sv
// xmem_dma shared definitions.
// State encoding for the databus DMA initiator FSM.
package xmem_dma_pkg;

  localparam int XDMA_STATE_W = 3;

  typedef enum logic [XDMA_STATE_W-1:0] {
    XDMA_IDLE  = 3'd0,
    XDMA_FETCH = 3'd1,
    XDMA_REQ   = 3'd2,
    XDMA_PUSH  = 3'd3,
    XDMA_DONE  = 3'd4
  } xdma_state_t;

endpackage

// File: rtl/xmem_dma.sv
// xmem_dma: moves a block of words between a stream
// and one Versat memory through its valid/ready port.
module xmem_dma
  import xmem_dma_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                ready,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] WAIT_ONE = CNT_W'(1);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  xdma_state_t r_state;
  xdma_state_t w_next;

  logic              r_dir;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [CNT_W-1:0]  r_wait;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_out_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_accept;
  logic w_launch;
  logic w_wr_cap;
  logic w_rd_cap;
  logic w_step;
  logic w_tmo_hit;
  logic w_last;
  logic w_tmo;
  logic w_dir;

  // last word when the incremented index reaches len
  assign w_last = (r_idx + IDX_ONE) == r_len;
  // a zero TIMEOUT never expires
  assign w_tmo = (TIMEOUT > 0) && (r_wait == WAIT_LAST);
  // direction is only on the input pins while idle
  assign w_dir = (r_state == XDMA_IDLE) ? dir : r_dir;

  // Next state and per-cycle transfer events.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_launch  = 1'b0;
    w_wr_cap  = 1'b0;
    w_rd_cap  = 1'b0;
    w_step    = 1'b0;
    w_tmo_hit = 1'b0;
    unique case (r_state)
      XDMA_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (len == '0) begin
            w_next = XDMA_DONE;
          end else begin
            w_launch = 1'b1;
            w_next = dir ? XDMA_REQ : XDMA_FETCH;
          end
        end
      end
      XDMA_FETCH: begin
        if (in_valid) begin
          w_wr_cap = 1'b1;
          w_next = XDMA_REQ;
        end
      end
      XDMA_REQ: begin
        // ready beats a same-cycle expiry
        if (ready) begin
          if (r_dir) begin
            w_rd_cap = 1'b1;
            w_next = XDMA_PUSH;
          end else begin
            w_step = 1'b1;
            w_next = w_last ? XDMA_DONE : XDMA_FETCH;
          end
        end else if (w_tmo) begin
          w_tmo_hit = 1'b1;
          w_next = XDMA_DONE;
        end
      end
      XDMA_PUSH: begin
        if (out_ready) begin
          w_step = 1'b1;
          w_next = w_last ? XDMA_DONE : XDMA_REQ;
        end
      end
      XDMA_DONE: w_next = XDMA_IDLE;
      default:   w_next = XDMA_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= XDMA_IDLE;
    else     r_state <= w_next;
  end

  // Transfer context: direction, length, index, wait count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir  <= 1'b0;
      r_len  <= '0;
      r_idx  <= '0;
      r_wait <= '0;
    end else begin
      if (w_launch) begin
        r_dir <= dir;
        r_len <= len;
        r_idx <= '0;
      end else if (w_step) begin
        r_idx <= r_idx + IDX_ONE;
      end
      if (r_state == XDMA_REQ) r_wait <= r_wait + WAIT_ONE;
      else                     r_wait <= '0;
    end
  end

  // Bus request registers, held steady through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_valid <= (w_next == XDMA_REQ);
      r_wstrb <= (w_next == XDMA_REQ && !w_dir) ? '1 : '0;
      if (w_launch)    r_addr <= base;
      else if (w_step) r_addr <= r_addr + ADDR_ONE;
      if (w_wr_cap) r_wdata <= in_data;
    end
  end

  // Read data capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_rd_cap) r_out_data <= rdata;
      r_busy <= (w_next != XDMA_IDLE);
      r_done <= (w_next == XDMA_DONE);
      if (w_accept)       r_err <= 1'b0;
      else if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  assign in_ready  = (r_state == XDMA_FETCH);
  assign out_valid = (r_state == XDMA_PUSH);
  assign out_data  = r_out_data;
  assign valid     = r_valid;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_xmem_dma.sv
// tb_xmem_dma: directed vectors against a latency
// responder model and a stream source/sink.
module tb_xmem_dma;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          ready = 1'b0;
  logic [DW-1:0] rdata = '0;

  xmem_dma #(
    .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir),
    .base(base), .len(len), .busy(busy), .done(done),
    .err(err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(ready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dir;
    logic [AW-1:0] base;
    logic [AW:0] len;
    int          lat;
    bit          resp;
    int          stall_word;
    int          stall_n;
    bit          med;
    logic [DW-1:0] seed;
    logic [DW-1:0] d0;
    int          words;
    int          nreq;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    int          busy;
    int          vhigh;
    bit          err;
  } vec_t;

  vec_t vt[11];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [1024];
  int  lat = 3;
  bit  resp = 1'b1;
  int  wcnt = 0;
  bit  pvalid = 1'b0;
  int  nreq, vhigh, nbus, nout, widx;
  int  stall_word = -1, stall_n = 0, stall_cnt = 0;
  bit  med = 1'b0;
  int  med_cnt = 0;
  bit  cur_dir;
  logic [AW-1:0] cur_base, a_first, a_last;
  logic [DW-1:0] cur_seed, first_out;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  // one clock: score handshakes, then drive next cycle
  task automatic tick();
    bit hs_in, hs_out, hs_bus;
    logic [AW-1:0] ea;
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    hs_bus = valid && ready;
    if (hs_out) begin
      ea = cur_base + nout[AW-1:0];
      if (nout == 0) first_out = out_data;
      chk("out_data", out_data, mem[ea]);
      nout++;
    end
    if (hs_bus) begin
      ea = cur_base + nbus[AW-1:0];
      chk("bus_addr", 32'(addr), 32'(ea));
      if (cur_dir) begin
        chk("rd_wstrb", 32'(wstrb), 32'd0);
      end else begin
        chk("wr_wstrb", 32'(wstrb), 32'hF);
        chk("wr_data", wdata, cur_seed + nbus);
        mem[addr] = wdata;
      end
      nbus++;
    end
    @(posedge clk);
    #1;
    if (hs_bus) chk("valid_gap", 32'(valid), 32'd0);
    if (hs_in) widx++;
    in_data = cur_seed + widx;
    in_valid = 1'b1;
    start = 1'b0;
    if (valid && !pvalid) begin
      nreq++;
      if (nreq == 1) a_first = addr;
      a_last = addr;
    end
    if (valid) vhigh++;
    pvalid = valid;
    wcnt = valid ? wcnt + 1 : 0;
    ready = resp && (wcnt > lat);
    rdata = ready ? mem[addr] : 32'hDEAD_BEEF;
    out_ready = 1'b1;
    if (out_valid && nout == stall_word &&
        stall_cnt < stall_n) begin
      out_ready = 1'b0;
      stall_cnt++;
    end
    if (med && in_ready && widx == 1 && med_cnt < 3) begin
      in_valid = 1'b0;
      ready = 1'b1;
      start = 1'b1;
      dir = 1'b1;
      len = 11'd5;
      med_cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  nbusy;
    bit  got;
    logic e;
    cur_dir = v.dir;
    cur_base = v.base;
    cur_seed = v.seed;
    lat = v.lat;
    resp = v.resp;
    stall_word = v.stall_word;
    stall_n = v.stall_n;
    stall_cnt = 0;
    med = v.med;
    med_cnt = 0;
    nreq = 0; vhigh = 0; nbus = 0; nout = 0; widx = 0;
    nbusy = 0; got = 1'b0; e = 1'b0;
    dir = v.dir;
    base = v.base;
    len = v.len;
    in_valid = 1'b1;
    in_data = v.seed;
    start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (busy) nbusy++;
      if (done) begin
        got = 1'b1;
        e = err;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", nbusy, v.busy);
    chk("nreq", nreq, v.nreq);
    chk("valid_cycles", vhigh, v.vhigh);
    chk("err_at_done", 32'(e), 32'(v.err));
    chk("words_moved", v.dir ? nout : nbus, v.words);
    if (v.nreq > 0) begin
      chk("first_addr", 32'(a_first), 32'(v.a_first));
      chk("last_addr", 32'(a_last), 32'(v.a_last));
    end
    if (v.dir && nout > 0)
      chk("first_word", first_out, v.d0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("err_held", 32'(err), 32'(v.err));
  endtask

  initial begin
    bit got;
    vt[0]  = '{1'b0, 10'd5, 11'd3, 3, 1'b1, -1, 0, 1'b0,
               32'hA, 32'h0, 3, 3, 10'd5, 10'd7, 16, 12, 1'b0};
    vt[1]  = '{1'b1, 10'd5, 11'd3, 3, 1'b1, -1, 0, 1'b0,
               32'h0, 32'hA, 3, 3, 10'd5, 10'd7, 16, 12, 1'b0};
    vt[2]  = '{1'b1, 10'd1022, 11'd4, 3, 1'b1, 2, 5, 1'b0,
               32'h0, 32'h1000_03FE, 4, 4, 10'd1022, 10'd1,
               26, 16, 1'b0};
    vt[3]  = '{1'b0, 10'd100, 11'd0, 3, 1'b1, -1, 0, 1'b0,
               32'h0, 32'h0, 0, 0, 10'd0, 10'd0, 1, 0, 1'b0};
    vt[4]  = '{1'b1, 10'd0, 11'd2, 3, 1'b0, -1, 0, 1'b0,
               32'h0, 32'h0, 0, 1, 10'd0, 10'd0, 9, 8, 1'b1};
    vt[5]  = '{1'b0, 10'd1020, 11'd6, 3, 1'b1, -1, 0, 1'b0,
               32'h50, 32'h0, 6, 6, 10'd1020, 10'd1,
               31, 24, 1'b0};
    vt[6]  = '{1'b1, 10'd1020, 11'd6, 3, 1'b1, -1, 0, 1'b0,
               32'h0, 32'h50, 6, 6, 10'd1020, 10'd1,
               31, 24, 1'b0};
    vt[7]  = '{1'b1, 10'd9, 11'd1, 7, 1'b1, -1, 0, 1'b0,
               32'h0, 32'h1000_0009, 1, 1, 10'd9, 10'd9,
               10, 8, 1'b0};
    vt[8]  = '{1'b0, 10'd200, 11'd3, 3, 1'b1, -1, 0, 1'b1,
               32'h77, 32'h0, 3, 3, 10'd200, 10'd202,
               19, 12, 1'b0};
    vt[9]  = '{1'b1, 10'd200, 11'd3, 3, 1'b1, -1, 0, 1'b0,
               32'h0, 32'h77, 3, 3, 10'd200, 10'd202,
               16, 12, 1'b0};
    vt[10] = '{1'b1, 10'd0, 11'd4, 3, 1'b1, -1, 0, 1'b0,
               32'h0, 32'h54, 4, 4, 10'd0, 10'd3,
               21, 16, 1'b0};

    for (int a = 0; a < 1024; a++)
      mem[a] = 32'h1000_0000 | a;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // reset while a read waits in REQ
    cur_dir = 1'b1; cur_base = '0; lat = 3; resp = 1'b1;
    stall_word = -1; med = 1'b0;
    nout = 0; nbus = 0; nreq = 0; vhigh = 0; widx = 0;
    dir = 1'b1; base = '0; len = 11'd4; start = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_reach_req", 32'(got), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b0;
    wcnt = 0;
    pvalid = 1'b0;
    @(posedge clk);
    #1;
    run_vec(vt[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
